rom_sequencer: RTL



---
 rtl/rom_seq_pkg.sv | 27 ++
 rtl/rom_sequencer_if.sv | 32 +++
 rtl/rom_sequencer_btn_edge.sv | 42 ++++
 rtl/rom_sequencer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/rom_seq_pkg.sv
// Shared definitions for the ROM sequencer.
// Contents:
//   seq_state_e - controller state (IDLE, RUN, DONE)
//   ADR_W/DAT_W - ROM address and data widths
//   next_adr    - address advance with wrap after the last used address
package rom_seq_pkg;

    localparam int ADR_W = 4;
    localparam int DAT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Advance the ROM address, returning to zero after the last used address.
    function automatic logic [ADR_W-1:0] next_adr(input logic [ADR_W-1:0] adr,
                                                  input logic [ADR_W-1:0] last);
        if (adr == last) begin
            return {ADR_W{1'b0}};
        end else begin
            return adr + ADR_W'(1);
        end
    endfunction

endpackage

// File: rtl/rom_sequencer_if.sv
// Bus between the sequencer, its button filters, its ROM and the display path.
// Signals:
//   btn_step, btn_run - debounced button levels (asynchronous to clk)
//   rom_adr, rom_dat  - ROM address out, combinational ROM data back
//   dat_out/dat_valid - last emitted word and its one-clock update strobe
//   busy, done        - RUN and DONE state flags
//   cur_adr           - address of the next word to emit
// Modports: master = sequencer side, slave = environment side.
interface rom_sequencer_if;
    import rom_seq_pkg::*;

    logic             btn_step;
    logic             btn_run;
    logic [ADR_W-1:0] rom_adr;
    logic [DAT_W-1:0] rom_dat;
    logic [DAT_W-1:0] dat_out;
    logic             dat_valid;
    logic             busy;
    logic             done;
    logic [ADR_W-1:0] cur_adr;

    modport master (
        input  btn_step, btn_run, rom_dat,
        output rom_adr, dat_out, dat_valid, busy, done, cur_adr
    );

    modport slave (
        output btn_step, btn_run, rom_dat,
        input  rom_adr, dat_out, dat_valid, busy, done, cur_adr
    );

endinterface

// File: rtl/rom_sequencer_btn_edge.sv
// Button synchroniser and rising-edge detector.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   btn        - debounced button level, asynchronous to clk
//   press      - one-clock pulse per rising level, acted on at the third
//                posedge after the level is first sampled
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic       s1_r;
    logic       s2_r;
    logic       s3_r;
    logic [1:0] prime_r;

    // Two-flop synchroniser, delay flop, and a priming counter that stays
    // below 3 until s3 holds a real sample, so a button already held across
    // reset release is taken as the baseline rather than a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r    <= 1'b0;
            s2_r    <= 1'b0;
            s3_r    <= 1'b0;
            prime_r <= 2'd0;
        end else begin
            s1_r <= btn;
            s2_r <= s1_r;
            s3_r <= s2_r;
            if (prime_r != 2'd3) begin
                prime_r <= prime_r + 2'd1;
            end else begin
                prime_r <= prime_r;
            end
        end
    end

    assign press = s2_r & ~s3_r & (prime_r == 2'd3);

endmodule

// File: rtl/rom_sequencer.sv
// ROM sequencer: steps through a 16 x 8 asynchronous-read ROM, one word per
// step press in IDLE, or one word every TICK_DIV clocks in RUN until the end
// word or the last address is reached.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - rom_sequencer_if master: buttons in, ROM address/data,
//                dat_out/dat_valid, busy, done, cur_adr out
module rom_sequencer
    import rom_seq_pkg::*;
#(
    parameter int               TICK_W   = 16,
    parameter int               TICK_DIV = 50000,
    parameter logic [ADR_W-1:0] LAST_ADR = 4'hF,
    parameter logic [DAT_W-1:0] END_CODE = 8'h00,
    parameter bit               USE_END  = 1'b1,
    parameter bit               WRAP     = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    rom_sequencer_if.master bus
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic             step_press_s;
    logic             run_press_s;
    seq_state_e       state_r;
    seq_state_e       state_nxt_s;
    logic [ADR_W-1:0] adr_r;
    logic [ADR_W-1:0] adr_nxt_s;
    logic [DAT_W-1:0] dat_r;
    logic [DAT_W-1:0] dat_nxt_s;
    logic             valid_r;
    logic             valid_nxt_s;
    logic [TICK_W-1:0] tick_r;
    logic [TICK_W-1:0] tick_nxt_s;
    logic             busy_r;
    logic             done_r;

    btn_edge u_step (.clk(clk), .rst_n(rst_n), .btn(bus.btn_step), .press(step_press_s));
    btn_edge u_run  (.clk(clk), .rst_n(rst_n), .btn(bus.btn_run),  .press(run_press_s));

    // Next-state, tick and emit decisions; run press takes priority over
    // step press and over a terminal tick.
    always_comb begin
        state_nxt_s = state_r;
        adr_nxt_s   = adr_r;
        dat_nxt_s   = dat_r;
        valid_nxt_s = 1'b0;
        tick_nxt_s  = tick_r;
        case (state_r)
            IDLE: begin
                if (run_press_s) begin
                    state_nxt_s = RUN;
                    tick_nxt_s  = {TICK_W{1'b0}};
                end else if (step_press_s) begin
                    dat_nxt_s   = bus.rom_dat;
                    valid_nxt_s = 1'b1;
                    adr_nxt_s   = next_adr(adr_r, LAST_ADR);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (run_press_s) begin
                    state_nxt_s = IDLE;
                    tick_nxt_s  = {TICK_W{1'b0}};
                end else if (tick_r == TICK_LAST) begin
                    dat_nxt_s   = bus.rom_dat;
                    valid_nxt_s = 1'b1;
                    adr_nxt_s   = next_adr(adr_r, LAST_ADR);
                    tick_nxt_s  = {TICK_W{1'b0}};
                    // The end word is still emitted; the stop takes effect after it.
                    if (USE_END && (bus.rom_dat == END_CODE)) begin
                        state_nxt_s = DONE;
                    end else if (!WRAP && (adr_r == LAST_ADR)) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    tick_nxt_s = tick_r + TICK_W'(1);
                end
            end
            DONE: begin
                if (run_press_s || step_press_s) begin
                    state_nxt_s = IDLE;
                    adr_nxt_s   = {ADR_W{1'b0}};
                    tick_nxt_s  = {TICK_W{1'b0}};
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                adr_nxt_s   = {ADR_W{1'b0}};
                tick_nxt_s  = {TICK_W{1'b0}};
            end
        endcase
    end

    // State, address, data and flag registers; flags decoded from next state
    // so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            adr_r   <= {ADR_W{1'b0}};
            dat_r   <= {DAT_W{1'b0}};
            valid_r <= 1'b0;
            tick_r  <= {TICK_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            adr_r   <= adr_nxt_s;
            dat_r   <= dat_nxt_s;
            valid_r <= valid_nxt_s;
            tick_r  <= tick_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    assign bus.rom_adr   = adr_r;
    assign bus.cur_adr   = adr_r;
    assign bus.dat_out   = dat_r;
    assign bus.dat_valid = valid_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule
